// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: frame output port of the 7-segment scan decoder.
//   word    : decoded frame, digit d in word[4d+3:4d]
//   bad     : per-digit flag, captured pattern was not a hex glyph
//   valid   : frame available on word/bad
//   ready   : consumer accepts frame when valid && ready
//   overrun : saturating count of frames dropped while valid was pending
// master = decoder side, slave = consumer side.
interface seven_seg_scan_if #(
   parameter int unsigned DIGITS = 8
);
   logic [4*DIGITS-1:0] word;
   logic [DIGITS-1:0]   bad;
   logic                valid;
   logic                ready;
   logic [7:0]          overrun;

   modport master (output word, bad, valid, overrun, input ready);
   modport slave  (input word, bad, valid, overrun, output ready);
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: snoops a multiplexed 7-segment display bus, waits for
// each digit's pattern to settle, decodes active-low segments to a hex nibble
// and offers one assembled word per complete scan frame on a valid/ready port.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous reset, active-low
//   an_i   : anode enables, active-low, exactly one low bit selects a digit
//   seg_i  : segments, active-low, bit0=a .. bit6=g
//   bus    : frame output (word/bad/valid/overrun out, ready in)
// Optional feature: define SEG7_DEC_OVERRUN_EN to count dropped frames in
// bus.overrun (saturating at 8'hFF); otherwise bus.overrun is tied to zero.
module seven_seg_scan_decoder #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned SETTLE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DIGITS-1:0]   an_i,
   input  logic [6:0]          seg_i,
   seven_seg_scan_if.master    bus
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      S_WAIT,
      S_SETTLING,
      S_HELD
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DIGITS-1:0]   prev_an;
   logic [6:0]          prev_seg;
   logic [DIGITS-1:0]   seen;
   logic [4*DIGITS-1:0] work_word;
   logic [DIGITS-1:0]   work_bad;

   logic [DIGITS-1:0]   an_inv_c;
   logic                an_ok_c;
   logic [IDX_W-1:0]    idx_c;
   logic                same_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                capture_c;
   logic [3:0]          nib_c;
   logic                glyph_bad_c;
   logic                frame_done_c;
   logic                slot_free_c;

   // Active-low segment pattern to {bad, nibble}; unknown patterns give nibble 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = 5'h00;
         7'h79:   r = 5'h01;
         7'h24:   r = 5'h02;
         7'h30:   r = 5'h03;
         7'h19:   r = 5'h04;
         7'h12:   r = 5'h05;
         7'h02:   r = 5'h06;
         7'h78:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h10:   r = 5'h09;
         7'h08:   r = 5'h0A;
         7'h03:   r = 5'h0B;
         7'h46:   r = 5'h0C;
         7'h21:   r = 5'h0D;
         7'h06:   r = 5'h0E;
         7'h0E:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   // Anode qualification, digit index and settle bookkeeping.
   always_comb begin
      an_inv_c    = ~an_i;
      an_ok_c     = (an_inv_c != '0) && ((an_inv_c & (an_inv_c - DIGITS'(1))) == '0);
      idx_c       = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (an_inv_c[i]) idx_c = IDX_W'(i);
      end
      same_c       = (an_i == prev_an) && (seg_i == prev_seg);
      cnt_inc_c    = cnt + CNT_W'(1);
      capture_c    = (state == S_SETTLING) && an_ok_c && same_c &&
                     (cnt_inc_c == CNT_W'(SETTLE));
      {glyph_bad_c, nib_c} = decode_glyph(seg_i);
      frame_done_c = &seen;
      // Output slot frees up on the same edge the consumer takes the old frame.
      slot_free_c  = !bus.valid || bus.ready;
   end

   // Settle FSM, frame assembly and output handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_WAIT;
         cnt       <= '0;
         prev_an   <= '1;
         prev_seg  <= '1;
         seen      <= '0;
         work_word <= '0;
         work_bad  <= '0;
         bus.word  <= '0;
         bus.bad   <= '0;
         bus.valid <= 1'b0;
      end else begin
         prev_an  <= an_i;
         prev_seg <= seg_i;

         case (state)
            S_WAIT: begin
               if (an_ok_c) begin
                  state <= S_SETTLING;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            S_SETTLING: begin
               if (!an_ok_c) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end else if (!same_c) begin
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt   <= cnt_inc_c;
                  if (capture_c) state <= S_HELD;
               end
            end
            S_HELD: begin
               if (!an_ok_c) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end else if (!same_c) begin
                  state <= S_SETTLING;
                  cnt   <= CNT_W'(1);
               end
            end
            default: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
         endcase

         if (bus.valid && bus.ready) bus.valid <= 1'b0;

         // Completed frame: load if the slot is free, otherwise drop it.
         if (frame_done_c) begin
            seen <= '0;
            if (slot_free_c) begin
               bus.word  <= work_word;
               bus.bad   <= work_bad;
               bus.valid <= 1'b1;
            end
         end

         // Placed after the frame clear so a same-edge capture is not lost.
         if (capture_c) begin
            work_word[{idx_c, 2'b00} +: 4] <= nib_c;
            work_bad[idx_c]                <= glyph_bad_c;
            seen[idx_c]                    <= 1'b1;
         end
      end
   end

`ifdef SEG7_DEC_OVERRUN_EN
   // Saturating count of frames dropped while the output slot was occupied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.overrun <= '0;
      end else if (frame_done_c && !slot_free_c && (bus.overrun != 8'hFF)) begin
         bus.overrun <= bus.overrun + 8'd1;
      end
   end
`else
   assign bus.overrun = 8'h00;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with DIGITS=2, SETTLE=4.
module tb_seven_seg_scan_decoder;

   localparam int unsigned DIGITS = 2;
   localparam int unsigned SETTLE = 4;

`ifdef SEG7_DEC_OVERRUN_EN
   localparam logic [7:0] EXP_OVR2 = 8'd2;
`else
   localparam logic [7:0] EXP_OVR2 = 8'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  an;
   logic [6:0]  seg;

   seven_seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seven_seg_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .an_i  (an),
      .seg_i (seg),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg0;
      logic [6:0] seg1;
      logic [7:0] exp_word;
      logic [1:0] exp_bad;
   } vec_t;

   vec_t vecs [20];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold (an, seg) for n rising edges; returns on a falling edge.
   task automatic drive(input logic [1:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      an        = 2'b11;
      seg       = 7'h7F;
      bus.ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Both digits captured; the frame loads on the following edge.
   task automatic send_frame(input logic [6:0] s0, input logic [6:0] s1);
      drive(2'b10, s0, SETTLE);
      drive(2'b01, s1, SETTLE);
   endtask

   initial begin
      vecs[0]  = '{7'h40, 7'h0E, 8'hF0, 2'b00};
      vecs[1]  = '{7'h79, 7'h06, 8'hE1, 2'b00};
      vecs[2]  = '{7'h24, 7'h21, 8'hD2, 2'b00};
      vecs[3]  = '{7'h30, 7'h46, 8'hC3, 2'b00};
      vecs[4]  = '{7'h19, 7'h03, 8'hB4, 2'b00};
      vecs[5]  = '{7'h12, 7'h08, 8'hA5, 2'b00};
      vecs[6]  = '{7'h02, 7'h10, 8'h96, 2'b00};
      vecs[7]  = '{7'h78, 7'h00, 8'h87, 2'b00};
      vecs[8]  = '{7'h00, 7'h78, 8'h78, 2'b00};
      vecs[9]  = '{7'h10, 7'h02, 8'h69, 2'b00};
      vecs[10] = '{7'h08, 7'h12, 8'h5A, 2'b00};
      vecs[11] = '{7'h03, 7'h19, 8'h4B, 2'b00};
      vecs[12] = '{7'h46, 7'h30, 8'h3C, 2'b00};
      vecs[13] = '{7'h21, 7'h24, 8'h2D, 2'b00};
      vecs[14] = '{7'h06, 7'h79, 8'h1E, 2'b00};
      vecs[15] = '{7'h0E, 7'h40, 8'h0F, 2'b00};
      vecs[16] = '{7'h24, 7'h06, 8'hE2, 2'b00};
      vecs[17] = '{7'h55, 7'h40, 8'h00, 2'b01};
      vecs[18] = '{7'h7F, 7'h24, 8'h20, 2'b01};
      vecs[19] = '{7'h55, 7'h7F, 8'h00, 2'b11};

      // Reset state
      do_reset();
      check("reset_word",    32'(bus.word),    32'h0);
      check("reset_bad",     32'(bus.bad),     32'h0);
      check("reset_valid",   32'(bus.valid),   32'h0);
      check("reset_overrun", 32'(bus.overrun), 32'h0);

      // Table: one frame per vector, ready held high
      for (int i = 0; i < 20; i++) begin
         send_frame(vecs[i].seg0, vecs[i].seg1);
         check($sformatf("vec%0d_pre_valid", i), 32'(bus.valid), 32'h0);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'h1);
         check($sformatf("vec%0d_word", i),  32'(bus.word),  32'(vecs[i].exp_word));
         check($sformatf("vec%0d_bad", i),   32'(bus.bad),   32'(vecs[i].exp_bad));
      end
      @(negedge clk);
      check("table_valid_cleared", 32'(bus.valid),   32'h0);
      check("table_overrun",       32'(bus.overrun), 32'h0);

      // Short settle (3 cycles) never captures digit 0
      do_reset();
      drive(2'b10, 7'h78, SETTLE - 1);
      drive(2'b11, 7'h78, 2);
      drive(2'b01, 7'h40, SETTLE + 3);
      check("short_settle_valid", 32'(bus.valid), 32'h0);

      // Invalid anode patterns never capture
      do_reset();
      for (int i = 0; i < 10; i++) drive(2'b00, 7'(i * 13), 1);
      for (int i = 0; i < 10; i++) drive(2'b11, 7'h40, 1);
      drive(2'b01, 7'h40, SETTLE + 3);
      check("bad_anode_valid", 32'(bus.valid), 32'h0);

      // Bounce restarts the count, then exact capture latency
      do_reset();
      drive(2'b10, 7'h79, 3);
      drive(2'b10, 7'h78, 1);
      drive(2'b10, 7'h79, 3);
      drive(2'b01, 7'h24, SETTLE + 2);
      check("bounce_no_frame", 32'(bus.valid), 32'h0);
      drive(2'b10, 7'h79, SETTLE);
      check("latency_capture_edge", 32'(bus.valid), 32'h0);
      @(negedge clk);
      check("latency_valid", 32'(bus.valid), 32'h1);
      check("latency_word",  32'(bus.word),  32'h21);

      // Reset after digit 0 capture discards partial frame
      do_reset();
      drive(2'b10, 7'h40, SETTLE + 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_word",  32'(bus.word),  32'h0);
      check("midrst_valid", 32'(bus.valid), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < SETTLE + 3; i++) begin
         drive(2'b01, 7'h79, 1);
         check($sformatf("midrst_digit1_c%0d", i), 32'(bus.valid), 32'h0);
      end

      // Backpressure: first frame held, next two dropped
      do_reset();
      bus.ready = 1'b0;
      send_frame(7'h24, 7'h79);
      @(negedge clk);
      send_frame(7'h19, 7'h30);
      @(negedge clk);
      send_frame(7'h02, 7'h12);
      @(negedge clk);
      check("bp_valid",   32'(bus.valid),   32'h1);
      check("bp_word",    32'(bus.word),    32'h12);
      check("bp_bad",     32'(bus.bad),     32'h0);
      check("bp_overrun", 32'(bus.overrun), 32'(EXP_OVR2));

      // Accept and reload on the same edge keeps valid high with new data
      send_frame(7'h78, 7'h00);
      check("b2b_pre_word", 32'(bus.word), 32'h12);
      bus.ready = 1'b1;
      @(negedge clk);
      check("b2b_valid",   32'(bus.valid),   32'h1);
      check("b2b_word",    32'(bus.word),    32'h87);
      check("b2b_overrun", 32'(bus.overrun), 32'(EXP_OVR2));
      @(negedge clk);
      check("b2b_drain", 32'(bus.valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
